// File: rtl/proc_control_if.sv
// proc_control_if: run/instr request and datapath control outputs of the sequencer
interface proc_control_if;
    logic        run;
    logic [15:0] instr;
    logic [2:0]  regSelect;
    logic        regRSelect;
    logic        immSelect;
    logic [15:0] imm;
    logic [7:0]  regWrite;
    logic        aWrite;
    logic        rWrite;
    logic [1:0]  aluOp;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] retired;
    modport master (
        output run, instr,
        input  regSelect, regRSelect, immSelect, imm, regWrite, aWrite, rWrite,
        input  aluOp, busy, done, illegal, retired
    );
    modport slave (
        input  run, instr,
        output regSelect, regRSelect, immSelect, imm, regWrite, aWrite, rWrite,
        output aluOp, busy, done, illegal, retired
    );
endinterface

// File: rtl/proc_control.sv
// proc_control: multi-cycle decode sequencer driving the bus mux, ALU and register enables
module proc_control (
    input logic           clk,
    input logic           reset,
    proc_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d, retired_q, retired_d;
    logic [3:0]  op;
    logic [2:0]  rx, ry;
    logic        alu, wr, aw, rw, dn, il;
    assign op  = ir_q[15:12];
    assign rx  = ir_q[11:9];
    assign ry  = ir_q[8:6];
    assign alu = op == 4'd2 || op == 4'd3 || op == 4'd4;
    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        bus.regSelect  = '0;
        bus.regRSelect = 1'b0;
        bus.immSelect  = 1'b0;
        bus.aluOp      = '0;
        wr             = 1'b0;
        aw             = 1'b0;
        rw             = 1'b0;
        dn             = 1'b0;
        il             = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = bus.run ? T1 : IDLE;
                ir_d    = bus.run ? bus.instr : ir_q;
            end
            T1: begin
                state_d       = alu ? T2 : IDLE;
                bus.regSelect = alu ? rx : (op == 4'd0 ? ry : 3'd0);
                bus.immSelect = op == 4'd1;
                aw            = alu;
                wr            = op == 4'd0 || op == 4'd1;
                dn            = !alu;
                il            = !alu && op > 4'd1;
            end
            T2: begin
                state_d       = T3;
                bus.regSelect = ry;
                bus.aluOp     = 2'(op - 4'd2);
                rw            = 1'b1;
            end
            default: begin
                state_d        = IDLE;
                bus.regRSelect = 1'b1;
                wr             = 1'b1;
                dn             = 1'b1;
            end
        endcase
        // reset blocks every write so an interrupted instruction leaves no trace
        bus.regWrite = (wr && !reset) ? 8'(1) << rx : '0;
        bus.aWrite   = aw && !reset;
        bus.rWrite   = rw && !reset;
        bus.done     = dn && !reset;
        bus.illegal  = il && !reset;
        bus.busy     = state_q != IDLE;
        bus.imm      = {{8{ir_q[7]}}, ir_q[7:0]};
        bus.retired  = retired_q;
        retired_d    = reset ? '0 : retired_q + 16'(bus.done);
        state_d      = reset ? IDLE : state_d;
        ir_d         = reset ? '0 : ir_d;
    end
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        ir_q      <= ir_d;
        retired_q <= retired_d;
    end
endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: random and directed stimulus checked every cycle against a step-queue model
module tb_proc_control;
    logic clk = 1'b0;
    logic reset;
    logic chk_on = 1'b0;
    int   vecs = 0, errs = 0;
    proc_control_if bus ();
    proc_control dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] rs;
        logic       rr, is;
        logic [7:0] rw;
        logic       aw, rwr;
        logic [1:0] op;
        logic       dn, il;
    } step_t;

    step_t       q[$];
    logic [15:0] m_ir = '0, m_ret = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // An accepted instruction becomes the list of per-cycle output steps it must produce
    function automatic void push_steps(input logic [15:0] i);
        logic [3:0] o = i[15:12];
        logic [2:0] x = i[11:9], y = i[8:6];
        step_t s;
        s = '0;
        if (o == 0) begin
            s.rs = y; s.rw = 8'(1) << x; s.dn = 1; q.push_back(s);
        end else if (o == 1) begin
            s.is = 1; s.rw = 8'(1) << x; s.dn = 1; q.push_back(s);
        end else if (o <= 4) begin
            s.rs = x; s.aw = 1; q.push_back(s);
            s = '0; s.rs = y; s.rwr = 1; s.op = (o == 3) ? 2'd1 : (o == 4) ? 2'd2 : 2'd0; q.push_back(s);
            s = '0; s.rr = 1; s.rw = 8'(1) << x; s.dn = 1; q.push_back(s);
        end else begin
            s.dn = 1; s.il = 1; q.push_back(s);
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_ir  = '0;
            m_ret = '0;
        end else if (q.size() != 0) begin
            if (q[0].dn) m_ret++;
            void'(q.pop_front());
        end else if (bus.run) begin
            m_ir = bus.instr;
            push_steps(bus.instr);
        end
    end

    always @(negedge clk) if (chk_on) begin
        step_t e, g;
        e = (q.size() != 0) ? q[0] : '0;
        if (reset) begin
            e.rw = '0; e.aw = 0; e.rwr = 0; e.dn = 0; e.il = 0;
        end
        g = {bus.regSelect, bus.regRSelect, bus.immSelect, bus.regWrite, bus.aWrite,
             bus.rWrite, bus.aluOp, bus.done, bus.illegal};
        chk("cycle", 64'({g, bus.busy, bus.imm, bus.retired}),
            64'({e, q.size() != 0, {{8{m_ir[7]}}, m_ir[7:0]}, m_ret}));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] i);
        bus.run = 1'b1;
        bus.instr = i;
        tick();
        bus.run = 1'b0;
        bus.instr = 16'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        bus.run = 1'b0;
        bus.instr = '0;
        repeat (3) tick();
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_imm", 64'(bus.imm), 0);
        chk("rst_retired", 64'(bus.retired), 0);
        tick();
        reset = 1'b0;
        issue(16'h0280);
        @(negedge clk);
        chk("mv_sel_wr_done", 64'({bus.regSelect, bus.regWrite, bus.done}), 64'({3'd2, 8'h02, 1'b1}));
        tick();
        @(negedge clk);
        chk("mv_after", 64'({bus.busy, bus.retired}), 64'({1'b0, 16'd1}));
        issue(16'h2280);
        @(negedge clk);
        chk("add_t1", 64'({bus.regSelect, bus.aWrite}), 64'({3'd1, 1'b1}));
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("add_t2_rst", 64'({bus.busy, bus.rWrite}), 64'({1'b1, 1'b0}));
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst", 64'({bus.busy, bus.regWrite, bus.retired}), 0);
        issue(16'h1EF6);
        @(negedge clk);
        chk("mvi_t1", 64'({bus.immSelect, bus.imm, bus.regWrite, bus.done}),
            64'({1'b1, 16'hFFF6, 8'h80, 1'b1}));
        tick();
        issue(16'h3700);
        @(negedge clk);
        chk("sub_t1", 64'({bus.regSelect, bus.aWrite}), 64'({3'd3, 1'b1}));
        tick();
        @(negedge clk);
        chk("sub_t2", 64'({bus.regSelect, bus.aluOp, bus.rWrite}), 64'({3'd4, 2'b01, 1'b1}));
        tick();
        @(negedge clk);
        chk("sub_t3", 64'({bus.regRSelect, bus.regWrite, bus.done}), 64'({1'b1, 8'h08, 1'b1}));
        tick();
        issue(16'h36C0);
        @(negedge clk);
        chk("subxx_t1", 64'(bus.regSelect), 3);
        tick();
        @(negedge clk);
        chk("subxx_t2", 64'(bus.regSelect), 3);
        tick();
        tick();
        issue(16'hF000);
        @(negedge clk);
        chk("illegal_t1", 64'({bus.done, bus.illegal, bus.regWrite}), 64'({1'b1, 1'b1, 8'h00}));
        tick();
        issue(16'h2280);
        tick();
        bus.run = 1'b1;
        bus.instr = 16'h1E05;
        tick();
        bus.run = 1'b0;
        @(negedge clk);
        chk("busy_ignore_t3", 64'({bus.regRSelect, bus.regWrite, bus.done}), 64'({1'b1, 8'h02, 1'b1}));
        tick();
        @(negedge clk);
        chk("busy_ignore_ir", 64'({bus.busy, bus.imm, bus.retired}), 64'({1'b0, 16'hFF80, 16'd5}));
        repeat (3000) begin
            tick();
            reset = $urandom_range(0, 99) < 2;
            bus.run = $urandom_range(0, 9) < 7;
            bus.instr = {($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15)),
                         12'($urandom)};
        end
        tick();
        reset = 1'b1;
        bus.run = 1'b1;
        bus.instr = 16'h0280;
        tick();
        tick();
        reset = 1'b0;
        repeat (2000) @(posedge clk);
        @(negedge clk);
        chk("run_held_rate", 64'(bus.retired), 1000);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/proc_control.md
# proc_control

Multi-cycle control sequencer for the 16-bit processor datapath. Accepts one instruction per `run` handshake and decodes it. Over 1–3 cycles it drives the bus-mux selects (`regSelect`, `regRSelect`, `immSelect`), the immediate value, the A/R register load enables, the ALU operation and the one-hot register-bank write enables. It sits between instruction fetch and the datapath and is the only block that drives the bus mux.

## Interface

Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: start request; sampled only in IDLE.
- `instr` in 16: instruction word; sampled together with `run`.
- `regSelect` out 3: bus-mux register index.
- `regRSelect` out 1: bus-mux selects R register.
- `immSelect` out 1: bus-mux selects immediate.
- `imm` out 16: sign-extended `IR[7:0]`.
- `regWrite` out 8: one-hot register-bank load enable.
- `aWrite` out 1: load A register from bus.
- `rWrite` out 1: load R register from ALU.
- `aluOp` out 2: ALU operation, 00 add, 01 sub, 10 and.
- `busy` out 1: high when state ≠ IDLE.
- `done` out 1: one-cycle pulse in the final step of an instruction.
- `illegal` out 1: one-cycle pulse together with `done` for an undefined opcode.
- `retired` out 16: count of completed instructions, legal and illegal.

## Operation

Instruction format:
- `op` = `instr[15:12]`, `rx` = `instr[11:9]`, `ry` = `instr[8:6]`, `imm8` = `instr[7:0]`.
- `imm8` overlaps `ry`; `ry` is unused by `mvi`.

Opcodes:
- 0 mv: rx ← ry
- 1 mvi: rx ← sext(imm8)
- 2 add: rx ← rx+ry
- 3 sub: rx ← rx−ry
- 4 and: rx ← rx&ry
- 5–15: illegal

State register and capture:
- States: IDLE, T1, T2, T3. The 16-bit IR is internal.
- IDLE with `run`=1: IR ← `instr`; next state T1.
- `run` is ignored in T1–T3.

Per-state outputs (combinational from state + IR). Unlisted outputs are 0, and `regSelect` = 0.
- mv, T1: `regSelect`=ry, `regWrite[rx]`=1, `done`=1 → IDLE.
- mvi, T1: `immSelect`=1, `regWrite[rx]`=1, `done`=1 → IDLE.
- ALU op, T1: `regSelect`=rx, `aWrite`=1 → T2.
- ALU op, T2: `regSelect`=ry, `aluOp` per opcode, `rWrite`=1 → T3.
- ALU op, T3: `regRSelect`=1, `regWrite[rx]`=1, `done`=1 → IDLE.
- illegal, T1: `done`=1, `illegal`=1, no enables → IDLE.

Invariants:
- `regRSelect` and `immSelect` are never high together.
- `regWrite` is zero or one-hot.
- `imm` is always `{{8{IR[7]}},IR[7:0]}`, including in IDLE.

Counter:
- `retired` increments by 1 on every edge where `done`=1.
- Wraps 0xFFFF → 0x0000.

Reset:
- `reset`=1 forces state IDLE, IR=0, `retired`=0 at the next edge.
- While `reset`=1, `regWrite`, `aWrite`, `rWrite`, `done` and `illegal` are gated to 0 combinationally. An instruction interrupted mid-sequence therefore performs no further writes and is not counted.
- Reset values: all outputs 0; `imm`=0.

## Timing

- Acceptance: `run` sampled at edge k in IDLE. T1 is the cycle after edge k; `busy`=1 from that cycle.
- Latency (cycles from acceptance edge to `done`): mv, mvi and illegal = 1; add, sub and and = 3.
- After `done`, the next cycle is IDLE. Minimum spacing is therefore one IDLE cycle between instructions; `run` held high continuously accepts a new instruction every 2 or 4 cycles.
- The datapath samples enables on the edge ending each state. rx=ry works because A is captured in T1 before any write to rx.
- `retired` updates on the edge ending the `done` cycle.

## Test plan

- **Reset.** Assert `reset` for 2 cycles mid-add (in T2).
  - Next cycle: `busy`=0, `regWrite`=0, `retired`=0.
  - No T3 write occurs.
- **mv.** `run`=1 with `instr`=0x0280 (mv r1,r2).
  - Cycle after acceptance: `regSelect`=2, `regWrite`=0x02, `done`=1.
  - Following cycle: `busy`=0, `retired`=1.
- **mvi.** `instr`=0x1EF6 (mvi r7,#0xF6).
  - T1: `immSelect`=1, `imm`=0xFFF6, `regWrite`=0x80, `done`=1.
- **sub with rx=ry.** `instr`=0x3700 (sub r3,r4).
  - T1: `regSelect`=3, `aWrite`=1.
  - T2: `regSelect`=4, `aluOp`=01, `rWrite`=1.
  - T3: `regRSelect`=1, `regWrite`=0x08, `done`=1.
  - Repeat with 0x36C0 (sub r3,r3): same selects, `regSelect`=3 in both T1 and T2.
- **Illegal and busy.** `instr`=0xF000: T1 shows `done`=1, `illegal`=1, `regWrite`=0.
  - Separately, pulse `run` with a new instruction during T2 of an add. It must be ignored: IR unchanged and the add completes normally.
- **Counter wrap.** Retire 65536 mv instructions with `run` held high. `retired` returns to 0x0000, and a new instruction is accepted every 2 cycles.
